// File: rtl/dffram_1rw1r_clr_if.sv
// Bus bundle for dffram_1rw1r_clr: read/write port 0, read-only port 1 and the
// zeroisation control. The owner of the RAM takes the slave side.
interface dffram_1rw1r_clr_if #(
  parameter int WSIZE  = 4,
  parameter int AWIDTH = 8
);
  logic               EN0;
  logic [WSIZE-1:0]   WE0;
  logic [AWIDTH-1:0]  A0;
  logic [WSIZE*8-1:0] Di0;
  logic [WSIZE*8-1:0] Do0;
  logic               EN1;
  logic [AWIDTH-1:0]  A1;
  logic [WSIZE*8-1:0] Do1;
  logic               CLR;
  logic               BUSY;

  modport master (
    output EN0, WE0, A0, Di0, EN1, A1, CLR,
    input  Do0, Do1, BUSY
  );

  modport slave (
    input  EN0, WE0, A0, Di0, EN1, A1, CLR,
    output Do0, Do1, BUSY
  );
endinterface

// File: rtl/dffram_1rw1r_clr.sv
// DFF-based 1RW + 1R RAM with byte-masked writes, optional port-1 write bypass
// and a zeroisation sweep that can be started by CLR or by reset release.
module dffram_1rw1r_clr #(
  parameter int WSIZE            = 4,
  parameter int WORDS            = 256,
  localparam int AWIDTH          = $clog2(WORDS),
  parameter bit CLEAR_ON_RESET   = 1'b1,
  parameter bit BYPASS           = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  dffram_1rw1r_clr_if.slave  bus
);

  localparam int DW = WSIZE * 8;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);
  localparam logic [AWIDTH:0]   WORDS_L   = (AWIDTH + 1)'(WORDS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AWIDTH-1:0] clr_cnt_r;
  logic [AWIDTH-1:0] clr_cnt_nxt_s;
  logic              clr_we_s;

  logic [DW-1:0]     mem_r [WORDS];
  logic [DW-1:0]     do0_r;
  logic [DW-1:0]     do1_r;

  logic              a0_ok_s;
  logic              a1_ok_s;
  logic              rd0_s;
  logic              rd1_s;
  logic              wr_s;
  logic              hit_s;
  logic [DW-1:0]     old0_s;
  logic [DW-1:0]     old1_s;
  logic [DW-1:0]     wr_word_s;
  logic [DW-1:0]     rd1_data_s;

  // WORDS need not be a power of two, so the top of the address space may be empty.
  function automatic logic addr_ok(input logic [AWIDTH-1:0] addr);
    return ({1'b0, addr} < WORDS_L);
  endfunction

  function automatic logic [DW-1:0] merge_bytes(
    input logic [DW-1:0]    old_w,
    input logic [DW-1:0]    new_w,
    input logic [WSIZE-1:0] be
  );
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < WSIZE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // User access decode; the sweep owns the array, so all user traffic is masked in CLEAR.
  always_comb begin
    a0_ok_s = addr_ok(bus.A0);
    a1_ok_s = addr_ok(bus.A1);
    rd0_s   = (state_r == ST_IDLE) && bus.EN0;
    rd1_s   = (state_r == ST_IDLE) && bus.EN1;
    wr_s    = rd0_s && a0_ok_s && (bus.WE0 != {WSIZE{1'b0}});
    hit_s   = BYPASS && wr_s && rd1_s && (bus.A0 == bus.A1);
    if (a0_ok_s) begin
      old0_s = mem_r[bus.A0];
    end else begin
      old0_s = {DW{1'b0}};
    end
    if (a1_ok_s) begin
      old1_s = mem_r[bus.A1];
    end else begin
      old1_s = {DW{1'b0}};
    end
    wr_word_s = merge_bytes(old0_s, bus.Di0, bus.WE0);
    if (hit_s) begin
      rd1_data_s = wr_word_s;
    end else begin
      rd1_data_s = old1_s;
    end
  end

  // Sequencer state and sweep counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= RESET_STATE;
      clr_cnt_r <= {AWIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next state: CLR starts a sweep from IDLE; CLR during a sweep has no effect.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    clr_we_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_cnt_nxt_s = {AWIDTH{1'b0}};
        if (bus.CLR) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt_s   = ST_IDLE;
          clr_cnt_nxt_s = {AWIDTH{1'b0}};
        end else begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = clr_cnt_r + AWIDTH'(1);
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        clr_cnt_nxt_s = {AWIDTH{1'b0}};
      end
    endcase
  end

  // Storage array; held untouched while reset is asserted.
  always_ff @(posedge CLK) begin
    if (RST_N && clr_we_s) begin
      mem_r[clr_cnt_r] <= {DW{1'b0}};
    end else if (RST_N && wr_s) begin
      mem_r[bus.A0] <= wr_word_s;
    end
  end

  // Registered read ports; Do0 is read-first, Do1 may see the same-cycle write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do0_r <= {DW{1'b0}};
      do1_r <= {DW{1'b0}};
    end else begin
      if (rd0_s) begin
        do0_r <= old0_s;
      end
      if (rd1_s) begin
        do1_r <= rd1_data_s;
      end
    end
  end

  assign bus.Do0  = do0_r;
  assign bus.Do1  = do1_r;
  assign bus.BUSY = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_dffram_1rw1r_clr.sv
// Scoreboard bench: one 256-word bypassing RAM and one 200-word non-bypassing RAM
// sharing clock and reset.
module tb_dffram_1rw1r_clr;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  string       sb_tag_q[$];
  logic [31:0] sb_exp_q[$];
  int          sb_src_q[$];

  always #5 CLK = ~CLK;

  dffram_1rw1r_clr_if #(.WSIZE(4), .AWIDTH(8)) bus_a ();
  dffram_1rw1r_clr_if #(.WSIZE(4), .AWIDTH(8)) bus_b ();

  dffram_1rw1r_clr #(.WSIZE(4), .WORDS(256), .CLEAR_ON_RESET(1'b1), .BYPASS(1'b1)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_a)
  );

  dffram_1rw1r_clr #(.WSIZE(4), .WORDS(200), .CLEAR_ON_RESET(1'b1), .BYPASS(1'b0)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.EN0 = 1'b0; bus_a.WE0 = 4'h0; bus_a.A0 = 8'h00; bus_a.Di0 = 32'h0;
    bus_a.EN1 = 1'b0; bus_a.A1 = 8'h00; bus_a.CLR = 1'b0;
    bus_b.EN0 = 1'b0; bus_b.WE0 = 4'h0; bus_b.A0 = 8'h00; bus_b.Di0 = 32'h0;
    bus_b.EN1 = 1'b0; bus_b.A1 = 8'h00; bus_b.CLR = 1'b0;
  endtask

  task automatic drain();
    string       tag;
    logic [31:0] exp;
    logic [31:0] got;
    int          src;
    while (sb_exp_q.size() > 0) begin
      tag = sb_tag_q.pop_front();
      exp = sb_exp_q.pop_front();
      src = sb_src_q.pop_front();
      case (src)
        0:       got = bus_a.Do0;
        1:       got = bus_a.Do1;
        2:       got = bus_b.Do0;
        default: got = bus_b.Do1;
      endcase
      check_val(tag, got, exp);
    end
  endtask

  // One clock cycle on DUT d (0 = A, 1 = B); c0/c1 push expected Do0/Do1 for this edge.
  task automatic step_cyc(input int d, input logic en0, input logic [3:0] we0,
                          input logic [7:0] a0, input logic [31:0] di0,
                          input logic en1, input logic [7:0] a1, input logic clr,
                          input logic c0, input logic [31:0] e0,
                          input logic c1, input logic [31:0] e1, input string tag);
    if (d == 0) begin
      bus_a.EN0 = en0; bus_a.WE0 = we0; bus_a.A0 = a0; bus_a.Di0 = di0;
      bus_a.EN1 = en1; bus_a.A1 = a1; bus_a.CLR = clr;
    end else begin
      bus_b.EN0 = en0; bus_b.WE0 = we0; bus_b.A0 = a0; bus_b.Di0 = di0;
      bus_b.EN1 = en1; bus_b.A1 = a1; bus_b.CLR = clr;
    end
    if (c0) begin
      sb_tag_q.push_back({tag, "_do0"}); sb_exp_q.push_back(e0); sb_src_q.push_back(d * 2);
    end
    if (c1) begin
      sb_tag_q.push_back({tag, "_do1"}); sb_exp_q.push_back(e1); sb_src_q.push_back(d * 2 + 1);
    end
    @(posedge CLK);
    @(negedge CLK);
    idle_all();
    drain();
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [31:0] data, input logic [3:0] m);
    step_cyc(d, 1'b1, m, a, data, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input int d, input logic [7:0] a0, input logic [31:0] e0,
                    input logic [7:0] a1, input logic [31:0] e1, input string tag);
    step_cyc(d, 1'b1, 4'h0, a0, 32'h0, 1'b1, a1, 1'b0, 1'b1, e0, 1'b1, e1, tag);
  endtask

  task automatic tick(input logic clr_a);
    step_cyc(0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, clr_a, 1'b0, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  // Counts clock edges until BUSY drops on each DUT; -1 when the bound expires.
  task automatic measure_busy(input int limit, output int ca, output int cb);
    ca = -1;
    cb = -1;
    for (int cyc_i = 0; cyc_i <= limit; cyc_i++) begin
      if (ca < 0 && !bus_a.BUSY) ca = cyc_i;
      if (cb < 0 && !bus_b.BUSY) cb = cyc_i;
      if (ca >= 0 && cb >= 0) break;
      @(negedge CLK);
    end
  endtask

  initial begin
    int ca;
    int cb;
    idle_all();
    #1 RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_val("rst_do0_a", bus_a.Do0, 32'h0);
    check_val("rst_do1_a", bus_a.Do1, 32'h0);
    check_val("rst_busy_a", {31'h0, bus_a.BUSY}, 32'h1);
    check_val("rst_busy_b", {31'h0, bus_b.BUSY}, 32'h1);
    RST_N = 1'b1;
    measure_busy(400, ca, cb);
    check_val("sweep_len_a", ca, 32'd256);
    check_val("sweep_len_b", cb, 32'd200);

    // Prefill, then reset must wipe it.
    wr(0, 8'h05, 32'hDEADBEEF, 4'hF);
    rd(0, 8'h05, 32'hDEADBEEF, 8'h05, 32'hDEADBEEF, "prefill");
    RST_N = 1'b0;
    #1;
    check_val("rst2_do0_a", bus_a.Do0, 32'h0);
    check_val("rst2_do1_a", bus_a.Do1, 32'h0);
    check_val("rst2_busy_a", {31'h0, bus_a.BUSY}, 32'h1);
    @(negedge CLK);
    RST_N = 1'b1;
    measure_busy(400, ca, cb);
    check_val("sweep2_len_a", ca, 32'd256);
    check_val("sweep2_len_b", cb, 32'd200);
    rd(0, 8'h05, 32'h0, 8'h05, 32'h0, "wiped");

    // Byte masks.
    wr(0, 8'h00, 32'hAA0055BB, 4'hF);
    wr(0, 8'h01, 32'hAA0055CC, 4'hF);
    wr(0, 8'h02, 32'hAA0055DD, 4'hF);
    wr(0, 8'h02, 32'h00000033, 4'h1);
    wr(0, 8'h01, 32'h00003300, 4'h2);
    wr(0, 8'h00, 32'h00330000, 4'h4);
    rd(0, 8'h00, 32'hAA3355BB, 8'h01, 32'hAA0033CC, "mask01");
    rd(0, 8'h02, 32'hAA005533, 8'h00, 32'hAA3355BB, "mask20");

    // Same-cycle collision on both builds.
    wr(0, 8'h10, 32'h11223344, 4'hF);
    wr(1, 8'h10, 32'h11223344, 4'hF);
    step_cyc(0, 1'b1, 4'h3, 8'h10, 32'hFFEEDDCC, 1'b1, 8'h10, 1'b0,
             1'b1, 32'h11223344, 1'b1, 32'h1122DDCC, "coll_a");
    step_cyc(1, 1'b1, 4'h3, 8'h10, 32'hFFEEDDCC, 1'b1, 8'h10, 1'b0,
             1'b1, 32'h11223344, 1'b1, 32'h11223344, "coll_b");
    rd(0, 8'h10, 32'h1122DDCC, 8'h10, 32'h1122DDCC, "post_coll_a");
    rd(1, 8'h10, 32'h1122DDCC, 8'h10, 32'h1122DDCC, "post_coll_b");

    // Out-of-range and last word on the 200-word build.
    step_cyc(1, 1'b1, 4'hF, 8'hF0, 32'hCAFEF00D, 1'b1, 8'hF0, 1'b0,
             1'b1, 32'h0, 1'b1, 32'h0, "oor_wr_b");
    rd(1, 8'h10, 32'h1122DDCC, 8'h10, 32'h1122DDCC, "pre_oor_b");
    rd(1, 8'hF0, 32'h0, 8'hF0, 32'h0, "oor_rd_b");
    wr(1, 8'hC7, 32'h5A5A1234, 4'hF);
    rd(1, 8'hC7, 32'h5A5A1234, 8'hC7, 32'h5A5A1234, "last_b");

    // CLR sweep with writes, reads and a second CLR issued during it.
    wr(0, 8'hF0, 32'h01010101, 4'hF);
    wr(0, 8'hF1, 32'h02020202, 4'hF);
    wr(0, 8'hF2, 32'h03030303, 4'hF);
    rd(0, 8'hF2, 32'h03030303, 8'hF1, 32'h02020202, "pre_clr");
    check_val("busy_idle_a", {31'h0, bus_a.BUSY}, 32'h0);
    tick(1'b1);
    check_val("busy_rise_a", {31'h0, bus_a.BUSY}, 32'h1);
    tick(1'b0);
    step_cyc(0, 1'b1, 4'hF, 8'h00, 32'h12345678, 1'b1, 8'hF0, 1'b0,
             1'b1, 32'h03030303, 1'b1, 32'h02020202, "sweep_hold");
    tick(1'b1);
    measure_busy(400, ca, cb);
    check_val("clr_len_a", ca + 3, 32'd256);
    rd(0, 8'hF0, 32'h0, 8'hF1, 32'h0, "clr_f0f1");
    rd(0, 8'hF2, 32'h0, 8'h00, 32'h0, "clr_f2_w0");

    // Reset at sweep cycle 100 restarts the sweep from word 0.
    wr(0, 8'hFF, 32'h77777777, 4'hF);
    tick(1'b1);
    for (int i = 0; i < 100; i++) tick(1'b0);
    check_val("busy_mid_a", {31'h0, bus_a.BUSY}, 32'h1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    measure_busy(400, ca, cb);
    check_val("restart_len_a", ca, 32'd256);
    check_val("restart_len_b", cb, 32'd200);
    rd(0, 8'hFF, 32'h0, 8'h10, 32'h0, "restart_wipe");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
